ng_imem_loader: RTL

- Instruction-side responder for ng_core: answers the core's 16-bit fetch address with a 16-bit instruction from on-chip program RAM.
- Also loads that RAM from a byte-wide valid/ready stream (host/UART side).
- Holds the core in reset while loading and releases it when the program is complete.
- Sits between the host loader interface and ng_core's addr/instruction/rst pins.

---
 rtl/ng_imem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ng_imem_loader.sv
// ng_imem_loader: program RAM for ng_core, loaded from a byte stream.
// The stream is a 16-bit little-endian word count N, then N words sent low byte first.
// The core is held in reset until the whole program is in RAM.
// Fetches are answered combinationally, and words past word_count read as zero.
module ng_imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [15:0]       addr,
   output logic [15:0]       instruction,
   output logic              core_rst_n,
   output logic              busy,
   output logic              len_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA_LO,
      DATA_HI,
      RUN,
      ERR
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         len_lo_q, len_lo_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [7:0]         lo_q, lo_d;
   logic [LEN_W-1:0]   wc_q, wc_d;
   logic               len_err_q, len_err_d;
   logic               byte_ready_q, byte_ready_d;
   logic               busy_q, busy_d;
   logic               core_rst_n_q, core_rst_n_d;

   logic               xfer_c;
   logic [15:0]        len_w_c;
   logic [LEN_W-1:0]   wc_inc_c;
   logic               we_c;
   logic [ADDR_W-1:0]  waddr_c;
   logic [15:0]        wdata_c;

   logic [15:0]        mem [DEPTH];

   // Control registers; the RAM itself is not reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         len_lo_q     <= '0;
         len_q        <= '0;
         lo_q         <= '0;
         wc_q         <= '0;
         len_err_q    <= 1'b0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         lo_q         <= lo_d;
         wc_q         <= wc_d;
         len_err_q    <= len_err_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   // Next state: each accepted byte advances the parser one step, and load_start overrides everything.
   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      lo_d         = lo_q;
      wc_d         = wc_q;
      len_err_d    = len_err_q;
      we_c         = 1'b0;
      xfer_c       = byte_valid & byte_ready_q;
      len_w_c      = {byte_data, len_lo_q};
      wc_inc_c     = wc_q + LEN_W'(1);
      waddr_c      = wc_q[ADDR_W-1:0];
      wdata_c      = {byte_data, lo_q};

      if (load_start) begin
         state_d   = LEN_LO;
         len_err_d = 1'b0;
         wc_d      = '0;
      end else if (xfer_c) begin
         case (state_q)
            LEN_LO: begin
               len_lo_d = byte_data;
               state_d  = LEN_HI;
            end
            LEN_HI: begin
               if (len_w_c == 16'h0000) begin
                  state_d = RUN;
               end else if (32'(len_w_c) > DEPTH) begin
                  state_d   = ERR;
                  len_err_d = 1'b1;
               end else begin
                  len_d   = LEN_W'(len_w_c);
                  state_d = DATA_LO;
               end
            end
            DATA_LO: begin
               lo_d    = byte_data;
               state_d = DATA_HI;
            end
            DATA_HI: begin
               we_c = 1'b1;
               wc_d = wc_inc_c;
               if (wc_inc_c == len_q) begin
                  state_d = RUN;
               end else begin
                  state_d = DATA_LO;
               end
            end
            default: ;
         endcase
      end

      byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA_LO) || (state_d == DATA_HI);
      busy_d       = byte_ready_d;
      // Release the core one cycle after RUN is entered, so the whole program is visible at the first fetch.
      core_rst_n_d = (state_q == RUN) && !load_start;
   end

   // Program RAM write port.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[waddr_c] <= wdata_c;
      end
   end

   // Zero-latency fetch, bounded by the number of words loaded so far.
   always_comb begin
      instruction = 16'h0000;
      if (addr < 16'(wc_q)) begin
         instruction = mem[addr[ADDR_W-1:0]];
      end
   end

   assign byte_ready = byte_ready_q;
   assign busy       = busy_q;
   assign core_rst_n = core_rst_n_q;
   assign len_err    = len_err_q;
   assign word_count = wc_q;

endmodule
